// File: rtl/junction_if.sv
// junction_if: the stream signals around the junction arbiter, grouped in one bundle.
//   i_tdata  [N*8] upstream bytes, source k in bits [8k+7:8k]
//   i_tlast  [N]   upstream end-of-packet, one bit per source
//   i_tvalid [N]   upstream valid, one bit per source
//   o_tready [N]   upstream ready, at most one bit high
//   o_tdata  [8]   merged output byte
//   o_tlast        merged end-of-packet
//   o_tvalid       merged valid
//   i_tready       downstream ready
// The slave modport is the arbiter's view. The master modport is the view of
// the sources and the sink around it.
interface junction_if #(
  parameter int N = 2
);
  logic [N*8-1:0] i_tdata;
  logic [N-1:0]   i_tlast;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   o_tready;
  logic [7:0]     o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           i_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, i_tready,
    output o_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, i_tready,
    input  o_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/junction.sv
// junction: N-input round-robin packet arbiter. It merges N AXI-Stream byte
// sources into a single byte stream. Once a source is granted, it keeps the
// grant until its tlast byte transfers, so packets never interleave. When
// HEADER is 1, each packet is preceded by a byte holding the source index.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    junction_if.slave:
//          i_tdata/i_tlast/i_tvalid  upstream inputs, one lane per source
//          o_tready                  upstream ready
//          o_tdata/o_tlast/o_tvalid  registered merged output
//          i_tready                  downstream ready
module junction #(
  parameter int N      = 2,
  parameter bit HEADER = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  junction_if.slave  bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic            load;
  logic            xfer;
  logic [N-1:0]    ready_vec;
  logic [7:0]      src_byte [N];

  for (genvar k = 0; k < N; k++) begin : g_bytes
    assign src_byte[k] = bus.i_tdata[8*k +: 8];
  end

  // The output register can take a new beat when it is empty or being drained.
  assign load = !bus.o_tvalid || bus.i_tready;

  // Round-robin search that starts just after last_grant. The loop walks from
  // the farthest candidate back to the nearest one, so the last hit is the
  // source closest to last_grant+1.
  always_comb begin
    pick = last_grant;
    idx  = '0;
    for (int i = N; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % N);
      if (bus.i_tvalid[idx]) pick = idx;
    end
  end

  // Only the granted source is ready, and only while a data beat can be loaded.
  always_comb begin
    ready_vec = '0;
    if (state == DATA) ready_vec[grant] = load;
  end

  assign bus.o_tready = ready_vec;
  assign xfer         = (state == DATA) && load && bus.i_tvalid[grant];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(N - 1);
      bus.o_tvalid <= 1'b0;
      bus.o_tdata  <= '0;
      bus.o_tlast  <= 1'b0;
    end else begin
      // A drained register with nothing new to load goes empty.
      if (load) bus.o_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.i_tvalid) begin
            grant <= pick;
            state <= HEADER ? HDR : DATA;
          end
        end
        HDR: begin
          if (load) begin
            bus.o_tvalid <= 1'b1;
            bus.o_tdata  <= 8'(grant);
            bus.o_tlast  <= 1'b0;
            state        <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            bus.o_tvalid <= 1'b1;
            bus.o_tdata  <= src_byte[grant];
            bus.o_tlast  <= bus.i_tlast[grant];
            if (bus.i_tlast[grant]) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
